// File: rtl/q7_pkg.sv
// Shared constants for the q7 strobe synchronizer: default chain depth and arm time.
`timescale 1ns/100ps
package q7_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int ARM_CYCLES_DEFAULT  = SYNC_STAGES_DEFAULT + 1;

    // Edges to wait after reset release before a rise may be trusted.
    function automatic int arm_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/q7_circuit_sync_chain.sv
// N-flop metastability synchronizer; latency SYNC_STAGES clk edges.
// No backpressure: free-running shift chain, sampled every edge.
`timescale 1ns/100ps
module sync_chain
    import q7_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] s;

    // Plain flop-to-flop chain: nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s <= '0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], d};
        end
    end

    assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/q7_circuit.sv
// Async strobe -> one outclk-cycle pulse per rising edge; pulse high SYNC_STAGES+1 edges after the rise.
// No backpressure: every qualified rise is emitted; edges arriving before the arm time are dropped.
`timescale 1ns/100ps
module q7_circuit
    import q7_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic outclk,
    input  logic reset_n,
    input  logic async_sig,
    input  logic vcc,
    input  logic gnd,
    output logic out_sync_sig
);

    localparam int ARM_CYCLES = arm_cycles(SYNC_STAGES);
    localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

    logic             sync_q;
    logic             prev;
    logic             rise;
    logic             armed;
    logic [CNT_W-1:0] arm_cnt;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk     (outclk),
        .reset_n (reset_n),
        .d       (async_sig),
        .q       (sync_q)
    );

    assign rise  = sync_q & ~prev;
    assign armed = (arm_cnt == CNT_W'(ARM_CYCLES));

    // Arming hides a level that was already high at reset release from the edge detector.
    always_ff @(posedge outclk) begin
        if (!reset_n) begin
            prev         <= 1'b0;
            arm_cnt      <= '0;
            out_sync_sig <= 1'b0;
        end else begin
            prev <= sync_q;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            out_sync_sig <= (armed & rise) ? vcc : gnd;
        end
    end

endmodule

// File: tb/tb_q7_circuit.sv
// Scoreboard bench for q7_circuit: each driven rise queues its expected pulse cycle.
`timescale 1ns/100ps
module tb_q7_circuit;

    logic outclk;
    logic reset_n;
    logic async_sig;
    logic vcc;
    logic gnd;
    logic out_sync_sig;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pulses      = 0;
    int last_pulse  = -100;
    bit mon_en      = 0;
    int exp_q[$];

    q7_circuit #(
        .SYNC_STAGES (2)
    ) dut (
        .outclk       (outclk),
        .reset_n      (reset_n),
        .async_sig    (async_sig),
        .vcc          (vcc),
        .gnd          (gnd),
        .out_sync_sig (out_sync_sig)
    );

    initial begin
        outclk = 1'b0;
        forever #10 outclk = ~outclk;
    end

    always @(posedge outclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Input change strictly between clock edges: E0 is the next posedge, pulse seen after E2 -> cyc+3.
    task automatic set_async(input logic v);
        if (v && !async_sig) exp_q.push_back(cyc + 3);
        async_sig = v;
    endtask

    task automatic do_reset(input bit check_out);
        reset_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge outclk);
            if (check_out) chk("reset_hold_out", {31'd0, out_sync_sig}, 32'd0);
        end
        reset_n = 1'b1;
    endtask

    always @(negedge outclk) begin
        if (mon_en) begin
            chk("out_known", {31'd0, $isunknown(out_sync_sig)}, 32'd0);
            if (out_sync_sig === 1'b1) begin
                pulses++;
                chk("pulse_gap", {31'd0, (cyc - last_pulse) > 1}, 32'd1);
                last_pulse = cyc;
                if (exp_q.size() == 0) chk("spurious_pulse", {31'd0, out_sync_sig}, 32'd0);
                else                   chk("pulse_cycle", cyc, exp_q.pop_front());
            end else if (exp_q.size() > 0 && cyc > exp_q[0]) begin
                chk("missed_pulse", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        int p0;
        int rises;
        int d;

        reset_n   = 1'b0;
        async_sig = 1'b0;
        vcc       = 1'b1;
        gnd       = 1'b0;

        // Reset state
        @(negedge outclk);
        chk("reset_out", {31'd0, out_sync_sig}, 32'd0);
        mon_en = 1;
        @(negedge outclk);
        @(negedge outclk);
        reset_n = 1'b1;

        // Slow strobe: rise at 500 ns, toggle every 22727.2 ns
        p0 = pulses;
        #(440);
        set_async(1'b1);
        for (int i = 0; i < 5; i++) begin
            #(22727.2);
            set_async(~async_sig);
        end
        repeat (10) @(negedge outclk);
        chk("slow_pulse_count", pulses - p0, 3);

        // Falling edge: no pulse for 20 cycles
        set_async(1'b1);
        repeat (10) @(negedge outclk);
        p0 = pulses;
        set_async(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge outclk);
            chk("fall_idle", {31'd0, out_sync_sig}, 32'd0);
        end
        chk("fall_pulse_count", pulses - p0, 0);

        // Level already high across reset release
        async_sig = 1'b1;
        p0 = pulses;
        do_reset(1);
        repeat (50) @(negedge outclk);
        chk("level_high_pulses", pulses - p0, 0);
        set_async(1'b0);
        repeat (5) @(negedge outclk);

        // Reset one cycle after a rise: pending edge dropped
        p0 = pulses;
        async_sig = 1'b1;
        @(negedge outclk);
        do_reset(1);
        repeat (10) @(negedge outclk);
        chk("mid_reset_pulses", pulses - p0, 0);
        set_async(1'b0);
        repeat (5) @(negedge outclk);
        set_async(1'b1);
        repeat (8) @(negedge outclk);
        chk("post_reset_rise", pulses - p0, 1);
        set_async(1'b0);
        repeat (5) @(negedge outclk);

        // Back-to-back minimum-width phases
        p0 = pulses;
        for (int i = 0; i < 1000; i++) begin
            set_async(1'b1);
            repeat (3) @(negedge outclk);
            set_async(1'b0);
            repeat (3) @(negedge outclk);
        end
        repeat (6) @(negedge outclk);
        chk("b2b_pulse_count", pulses - p0, 1000);

        // Output drive values come from vcc/gnd
        mon_en = 0;
        vcc = 1'b0;
        async_sig = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge outclk);
            chk("vcc0_out", {31'd0, out_sync_sig}, 32'd0);
        end
        async_sig = 1'b0;
        repeat (4) @(negedge outclk);
        gnd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge outclk);
            chk("gnd1_idle", {31'd0, out_sync_sig}, 32'd1);
        end
        gnd = 1'b0;
        vcc = 1'b1;
        repeat (2) @(negedge outclk);
        chk("restored_idle", {31'd0, out_sync_sig}, 32'd0);
        mon_en = 1;

        // Random phase vs outclk, never on a rising clock edge
        @(negedge outclk);
        p0    = pulses;
        rises = 0;
        for (int i = 0; i < 10000; i++) begin
            d = int'($urandom_range(65, 120));
            while ((($time + 64'(d)) % 64'd20) == 64'd10) d++;
            #(d);
            if (!async_sig) rises++;
            set_async(~async_sig);
        end
        repeat (10) @(negedge outclk);
        chk("rand_pulse_count", pulses - p0, rises);

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
